test_card_gen: RTL and testbench

TEST_CARD_GEN -- requirements
Module: test_card_gen

---
 rtl/test_card_pkg.sv | 53 +++++
 rtl/test_card_palette.sv | 22 ++
 rtl/test_card_gen.sv | 174 +++++++++++++++++
 tb/tb_test_card_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/test_card_pkg.sv
// Shared definitions for the test card generator: mode encodings and the
// eight-entry bar palette expressed as abstract channel levels.
package test_card_pkg;

    typedef enum logic [1:0] {
        ModeVBars   = 2'd0,
        ModeHBars   = 2'd1,
        ModeChecker = 2'd2,
        ModeGrad    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        LvlZero,
        LvlFull,
        LvlGreyLo,
        LvlGreyHi
    } level_e;

    typedef struct packed {
        level_e r;
        level_e g;
        level_e b;
    } pal_entry_t;

    // Bar order: red, yellow, green, cyan, blue, magenta, grey-low, grey-high.
    function automatic pal_entry_t pal_entry(input logic [2:0] idx);
        pal_entry_t e;
        unique case (idx)
            3'd0: e = '{r: LvlFull,   g: LvlZero,   b: LvlZero};
            3'd1: e = '{r: LvlFull,   g: LvlFull,   b: LvlZero};
            3'd2: e = '{r: LvlZero,   g: LvlFull,   b: LvlZero};
            3'd3: e = '{r: LvlZero,   g: LvlFull,   b: LvlFull};
            3'd4: e = '{r: LvlZero,   g: LvlZero,   b: LvlFull};
            3'd5: e = '{r: LvlFull,   g: LvlZero,   b: LvlFull};
            3'd6: e = '{r: LvlGreyLo, g: LvlGreyLo, b: LvlGreyLo};
            3'd7: e = '{r: LvlGreyHi, g: LvlGreyHi, b: LvlGreyHi};
        endcase
        return e;
    endfunction

    // Channel value for a level at a given channel width (4..16 bits).
    function automatic logic [15:0] level_value(input level_e lvl, input int unsigned bits);
        logic [15:0] v;
        unique case (lvl)
            LvlZero:   v = 16'd0;
            LvlFull:   v = 16'((32'd1 << bits) - 32'd1);
            LvlGreyLo: v = 16'((32'd1 << (bits - 2)) - 32'd1);
            LvlGreyHi: v = 16'(32'd1 << (bits - 1));
        endcase
        return v;
    endfunction

endpackage

// File: rtl/test_card_palette.sv
// Combinational palette lookup: bar index to RGB at COLR_BITS per channel.
module test_card_palette
    import test_card_pkg::*;
#(
    parameter int unsigned COLR_BITS = 8
) (
    input  logic [2:0]           i_idx,
    output logic [COLR_BITS-1:0] o_red,
    output logic [COLR_BITS-1:0] o_green,
    output logic [COLR_BITS-1:0] o_blue
);

    pal_entry_t w_entry;

    always_comb begin
        w_entry = pal_entry(i_idx);
        o_red   = COLR_BITS'(level_value(w_entry.r, COLR_BITS));
        o_green = COLR_BITS'(level_value(w_entry.g, COLR_BITS));
        o_blue  = COLR_BITS'(level_value(w_entry.b, COLR_BITS));
    end

endmodule

// File: rtl/test_card_gen.sv
// Test card generator: bars / checkerboard / gradient with optional horizontal
// scroll, two-stage registered pixel pipeline.
module test_card_gen
    import test_card_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned COLR_BITS   = 8,
    parameter int unsigned BANDS       = 8,
    parameter int unsigned CHECK_LOG2  = 5,
    parameter int unsigned SCROLL_STEP = 4,
    parameter int unsigned GRAD_SHIFT  = 1
) (
    input  logic                 i_pix_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_x,
    input  logic [15:0]          i_y,
    input  logic                 i_de,
    input  logic                 i_frame,
    input  logic [1:0]           i_mode,
    input  logic                 i_scroll_en,
    output logic [COLR_BITS-1:0] o_red,
    output logic [COLR_BITS-1:0] o_green,
    output logic [COLR_BITS-1:0] o_blue,
    output logic                 o_de
);

    localparam int unsigned LOG2_BANDS = $clog2(BANDS);
    localparam int unsigned HW = H_RES >> LOG2_BANDS;
    localparam int unsigned VW = V_RES >> LOG2_BANDS;
    localparam logic [COLR_BITS-1:0] COLR_MAX = '1;

    // Band index (mod 8) by comparing against every band boundary.
    function automatic logic [2:0] band_idx(input logic [15:0] v, input int unsigned w);
        logic [2:0] k;
        k = '0;
        for (int unsigned j = 1; j < BANDS; j++) begin
            if (32'(v) >= j * w) k = 3'(j);
        end
        return k;
    endfunction

    logic [15:0]          r_offset;
    mode_e                r_mode;
    logic                 r_s1_valid;
    logic                 r_s1_de;
    mode_e                r_s1_mode;
    logic [15:0]          r_s1_xe;
    logic [15:0]          r_s1_y;
    logic [COLR_BITS-1:0] r_red;
    logic [COLR_BITS-1:0] r_green;
    logic [COLR_BITS-1:0] r_blue;
    logic                 r_de;

    logic [16:0]          w_xsum;
    logic [15:0]          w_xe;
    logic                 w_valid;
    logic [16:0]          w_off_sum;
    logic [15:0]          w_off_next;

    always_comb begin
        w_xsum     = {1'b0, i_x} + {1'b0, r_offset};
        w_xe       = (w_xsum >= 17'(H_RES)) ? 16'(w_xsum - 17'(H_RES)) : w_xsum[15:0];
        w_valid    = i_de && (i_x < 16'(H_RES)) && (i_y < 16'(V_RES));
        w_off_sum  = {1'b0, r_offset} + 17'(SCROLL_STEP);
        w_off_next = (w_off_sum >= 17'(H_RES)) ? 16'(w_off_sum - 17'(H_RES))
                                               : w_off_sum[15:0];
    end

    // Stage 2 colour selection from the stage 1 registers.
    logic [2:0]           w_k;
    logic                 w_beyond;
    logic [15:0]          w_grad;
    logic [COLR_BITS-1:0] w_grad_sat;
    logic                 w_chk_on;
    logic [COLR_BITS-1:0] w_pal_red;
    logic [COLR_BITS-1:0] w_pal_green;
    logic [COLR_BITS-1:0] w_pal_blue;
    logic [COLR_BITS-1:0] w_red;
    logic [COLR_BITS-1:0] w_green;
    logic [COLR_BITS-1:0] w_blue;

    always_comb begin
        if (r_s1_mode == ModeHBars) begin
            w_k      = band_idx(r_s1_y, VW);
            w_beyond = 32'(r_s1_y) >= BANDS * VW;
        end else begin
            w_k      = band_idx(r_s1_xe, HW);
            w_beyond = 32'(r_s1_xe) >= BANDS * HW;
        end
        w_grad     = r_s1_xe >> GRAD_SHIFT;
        w_grad_sat = (w_grad > 16'(COLR_MAX)) ? COLR_MAX : w_grad[COLR_BITS-1:0];
        w_chk_on   = ~(r_s1_xe[CHECK_LOG2] ^ r_s1_y[CHECK_LOG2]);
    end

    test_card_palette #(
        .COLR_BITS (COLR_BITS)
    ) u_palette (
        .i_idx   (w_k),
        .o_red   (w_pal_red),
        .o_green (w_pal_green),
        .o_blue  (w_pal_blue)
    );

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (r_s1_valid) begin
            unique case (r_s1_mode)
                ModeVBars, ModeHBars: begin
                    if (!w_beyond) begin
                        w_red   = w_pal_red;
                        w_green = w_pal_green;
                        w_blue  = w_pal_blue;
                    end
                end
                ModeChecker: begin
                    if (w_chk_on) begin
                        w_red   = COLR_MAX;
                        w_green = COLR_MAX;
                        w_blue  = COLR_MAX;
                    end
                end
                ModeGrad: begin
                    w_red   = w_grad_sat;
                    w_green = w_grad_sat;
                    w_blue  = w_grad_sat;
                end
            endcase
        end
    end

    // Frame-rate control: a pixel sharing the i_frame cycle still sees old values.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_offset <= '0;
            r_mode   <= ModeVBars;
        end else if (i_frame) begin
            r_mode <= mode_e'(i_mode);
            if (i_scroll_en) r_offset <= w_off_next;
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_de    <= 1'b0;
            r_s1_mode  <= ModeVBars;
            r_s1_xe    <= '0;
            r_s1_y     <= '0;
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
            r_de       <= 1'b0;
        end else begin
            r_s1_valid <= w_valid;
            r_s1_de    <= i_de;
            r_s1_mode  <= r_mode;
            r_s1_xe    <= w_xe;
            r_s1_y     <= i_y;
            r_red      <= w_red;
            r_green    <= w_green;
            r_blue     <= w_blue;
            r_de       <= r_s1_de;
        end
    end

    assign o_red   = r_red;
    assign o_green = r_green;
    assign o_blue  = r_blue;
    assign o_de    = r_de;

endmodule

// File: tb/tb_test_card_gen.sv
// Self-checking bench for test_card_gen: frame-level reference model compared
// every cycle, plus directed pixels with hand-computed colours.
module tb_test_card_gen;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int BANDS       = 8;
    localparam int CHECK       = 32;
    localparam int SCROLL_STEP = 4;
    localparam int GRAD_SHIFT  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic        de;
    logic        frame;
    logic [1:0]  mode;
    logic        scroll_en;
    logic [7:0]  o_red;
    logic [7:0]  o_green;
    logic [7:0]  o_blue;
    logic        o_de;

    always #5 clk = ~clk;

    test_card_gen dut (
        .i_pix_clk   (clk),
        .i_rst       (rst),
        .i_x         (x),
        .i_y         (y),
        .i_de        (de),
        .i_frame     (frame),
        .i_mode      (mode),
        .i_scroll_en (scroll_en),
        .o_red       (o_red),
        .o_green     (o_green),
        .o_blue      (o_blue),
        .o_de        (o_de)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [23:0] pal [8] = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
                             24'h0000FF, 24'hFF00FF, 24'h3F3F3F, 24'h808080};

    // Reference colour straight from the pattern definitions.
    function automatic logic [23:0] model_rgb(int px, int py, bit pde, int pmode, int off);
        int xe;
        int k;
        int g;
        logic [7:0] v;
        if (!pde || px >= H_RES || py >= V_RES) return 24'h0;
        xe = (px + off) % H_RES;
        case (pmode)
            0: begin
                k = xe / (H_RES / BANDS);
                return (k >= BANDS) ? 24'h0 : pal[k % 8];
            end
            1: begin
                k = py / (V_RES / BANDS);
                return (k >= BANDS) ? 24'h0 : pal[k % 8];
            end
            2: return (((xe / CHECK) + (py / CHECK)) % 2 == 0) ? 24'hFFFFFF : 24'h0;
            default: begin
                g = xe >> GRAD_SHIFT;
                if (g > 255) g = 255;
                v = 8'(g);
                return {v, v, v};
            end
        endcase
    endfunction

    int          m_off = 0;
    int          m_mode = 0;
    logic [24:0] exp1 = '0;
    logic [24:0] exp2 = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_off  = 0;
            m_mode = 0;
            exp1   = '0;
            exp2   = '0;
        end else begin
            exp2 = exp1;
            exp1 = {de, model_rgb(int'(x), int'(y), de, m_mode, m_off)};
            if (frame) begin
                m_mode = int'(mode);
                if (scroll_en) m_off = (m_off + SCROLL_STEP) % H_RES;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({o_de, o_red, o_green, o_blue} !== exp2) begin
                errors++;
                $display("FAIL pipe t=%0t got de=%b rgb=%h exp de=%b rgb=%h",
                         $time, o_de, {o_red, o_green, o_blue}, exp2[24], exp2[23:0]);
            end
        end
    end

    task automatic lit_check(input string name, input logic want_de, input logic [23:0] want);
        checks++;
        if (o_de !== want_de || {o_red, o_green, o_blue} !== want) begin
            errors++;
            $display("FAIL %s got de=%b rgb=%h exp de=%b rgb=%h",
                     name, o_de, {o_red, o_green, o_blue}, want_de, want);
        end
    endtask

    task automatic pix_check(input string name, input int px, input int py,
                             input logic [23:0] want);
        @(negedge clk);
        x  = 16'(px);
        y  = 16'(py);
        de = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lit_check(name, 1'b1, want);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; de = 1'b0; frame = 1'b0; mode = 2'd0; scroll_en = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        lit_check("reset", 1'b0, 24'h0);
        rst = 1'b0;

        // Vertical bars, no scroll
        pix_check("bars_x0",   0,   0, 24'hFF0000);
        pix_check("bars_x480", 480, 0, 24'h3F3F3F);
        pix_check("bars_x560", 560, 0, 24'h808080);
        pix_check("bars_x640", 640, 0, 24'h000000);
        pix_check("bars_y480", 10,  480, 24'h000000);

        // Scroll by three frames: offset 12
        scroll_en = 1'b1;
        repeat (3) frame_pulse();
        scroll_en = 1'b0;
        pix_check("scroll_x68",  68,  0, 24'hFFFF00);
        pix_check("scroll_x630", 630, 0, 24'hFF0000);

        // Mode change without a frame pulse is ignored
        mode = 2'd1;
        pix_check("latch_hold", 68, 60, 24'hFFFF00);
        frame_pulse();
        pix_check("hbars_y60",  0, 60,  24'hFFFF00);
        pix_check("hbars_y0",   0, 0,   24'hFF0000);
        pix_check("hbars_y479", 5, 479, 24'h808080);

        // Checkerboard with offset still 12
        mode = 2'd2;
        frame_pulse();
        pix_check("chk_0_0",   0,  0,  24'hFFFFFF);
        pix_check("chk_32_0",  32, 0,  24'h000000);
        pix_check("chk_32_32", 32, 32, 24'hFFFFFF);
        pix_check("chk_20_0",  20, 0,  24'h000000);

        // One-cycle reset colliding with a frame pulse
        @(negedge clk);
        rst = 1'b1; frame = 1'b1; scroll_en = 1'b1; mode = 2'd3;
        @(negedge clk);
        rst = 1'b0; frame = 1'b0; scroll_en = 1'b0; mode = 2'd0;
        x = 16'd0; y = 16'd0; de = 1'b1;
        lit_check("rst_out", 1'b0, 24'h0);
        @(negedge clk);
        lit_check("rst_flush", 1'b0, 24'h0);
        @(negedge clk);
        lit_check("rst_bars", 1'b1, 24'hFF0000);

        // Gradient, offset 0
        mode = 2'd3;
        frame_pulse();
        pix_check("grad_x100", 100, 0, 24'h323232);
        pix_check("grad_x600", 600, 0, 24'hFFFFFF);
        pix_check("grad_x0",   0,   0, 24'h000000);

        // Data enable low blanks the output
        @(negedge clk);
        de = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lit_check("de_low", 1'b0, 24'h0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
